// File: rtl/nbody_step_engine.sv
`default_nettype none
// ============================================================================
// Module      : nbody_step_engine
// Description : Holds N_BODIES bodies (position, velocity) and advances the
//               whole system by one time step per start request. Pairwise
//               attraction terms go through one shared force datapath, one
//               (i,j) pair per clock. All new states are built in a shadow
//               bank from the old positions, then committed in one cycle.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               start, busy, done - step request / in progress / commit pulse
//               load_*            - write one body while idle
//               rd_idx, rd_*      - combinational read of committed state
// Revision    : 1.0 - initial release
// ============================================================================
module nbody_step_engine #(
   parameter int N_BODIES  = 8,
   parameter int POS_W     = 8,
   parameter int VEL_W     = 14,
   parameter int FRAC_W    = 7,
   parameter int GAIN      = 1,
   parameter int WRAP_MODE = 1,
   parameter int IDX_W     = $clog2(N_BODIES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             load_en,
   input  logic [IDX_W-1:0] load_idx,
   input  logic [POS_W-1:0] load_x,
   input  logic [POS_W-1:0] load_y,
   input  logic [VEL_W-1:0] load_vx,
   input  logic [VEL_W-1:0] load_vy,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [POS_W-1:0] rd_x,
   output logic [POS_W-1:0] rd_y,
   output logic [VEL_W-1:0] rd_vx,
   output logic [VEL_W-1:0] rd_vy
);

   localparam int ACC_W = VEL_W + IDX_W + 2;
   localparam int D_W   = POS_W + 1;
   localparam int S_W   = ((POS_W > VEL_W) ? POS_W : VEL_W) + 2;

   localparam logic [IDX_W-1:0]        c_last_idx = IDX_W'(N_BODIES - 1);
   localparam logic signed [ACC_W-1:0] c_gain     = ACC_W'(GAIN);
   localparam logic signed [ACC_W:0]   c_vel_max  =
      {{(ACC_W + 2 - VEL_W){1'b0}}, {(VEL_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0]   c_vel_min  =
      {{(ACC_W + 2 - VEL_W){1'b1}}, {(VEL_W - 1){1'b0}}};
   localparam logic signed [S_W-1:0]   c_pos_max  =
      {{(S_W - POS_W){1'b0}}, {POS_W{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_UPDATE = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   w_begin_step;
   logic   w_load;

   // Committed bank (what the outside world sees) and shadow bank (results
   // of the step in progress).
   logic        [POS_W-1:0] r_x  [N_BODIES];
   logic        [POS_W-1:0] r_y  [N_BODIES];
   logic signed [VEL_W-1:0] r_vx [N_BODIES];
   logic signed [VEL_W-1:0] r_vy [N_BODIES];
   logic        [POS_W-1:0] r_sx [N_BODIES];
   logic        [POS_W-1:0] r_sy [N_BODIES];
   logic signed [VEL_W-1:0] r_svx[N_BODIES];
   logic signed [VEL_W-1:0] r_svy[N_BODIES];

   logic        [IDX_W-1:0] r_i;
   logic        [IDX_W-1:0] r_j;
   logic signed [ACC_W-1:0] r_acc_x;
   logic signed [ACC_W-1:0] r_acc_y;

   logic signed [ACC_W-1:0] w_fx;
   logic signed [ACC_W-1:0] w_fy;
   logic signed [VEL_W-1:0] w_new_vx;
   logic signed [VEL_W-1:0] w_new_vy;
   logic        [POS_W-1:0] w_new_x;
   logic        [POS_W-1:0] w_new_y;

   // Signed distance other-own in POS_W+1 bits, scaled by the gain.
   function automatic logic signed [ACC_W-1:0] pair_force(
      input logic [POS_W-1:0] p_own,
      input logic [POS_W-1:0] p_other
   );
      logic signed [D_W-1:0]   d;
      logic signed [ACC_W-1:0] d_ext;
      d     = $signed({1'b0, p_other}) - $signed({1'b0, p_own});
      d_ext = {{(ACC_W - D_W){d[D_W-1]}}, d};
      return d_ext * c_gain;
   endfunction

   // Velocity plus accumulated force, saturated to the VEL_W signed range.
   function automatic logic signed [VEL_W-1:0] sat_vel(
      input logic signed [VEL_W-1:0] v,
      input logic signed [ACC_W-1:0] a
   );
      logic signed [ACC_W:0] s;
      s = {{(ACC_W + 1 - VEL_W){v[VEL_W-1]}}, v} + {a[ACC_W-1], a};
      if (s > c_vel_max) begin
         return c_vel_max[VEL_W-1:0];
      end else if (s < c_vel_min) begin
         return c_vel_min[VEL_W-1:0];
      end else begin
         return s[VEL_W-1:0];
      end
   endfunction

   // Position advanced by the integer part of the new velocity (floor via
   // arithmetic shift), then folded back into range by wrap or clamp.
   function automatic logic [POS_W-1:0] pos_step(
      input logic        [POS_W-1:0] p,
      input logic signed [VEL_W-1:0] v
   );
      logic signed [VEL_W-1:0] sh;
      logic signed [S_W-1:0]   sum;
      sh  = v >>> FRAC_W;
      sum = $signed({{(S_W - POS_W){1'b0}}, p}) +
            $signed({{(S_W - VEL_W){sh[VEL_W-1]}}, sh});
      if (WRAP_MODE != 0) begin
         return sum[POS_W-1:0];
      end else if (sum[S_W-1]) begin
         return '0;
      end else if (sum > c_pos_max) begin
         return '1;
      end else begin
         return sum[POS_W-1:0];
      end
   endfunction

   // The force path and the update path only ever see the committed bank.
   assign w_fx     = pair_force(r_x[r_i], r_x[r_j]);
   assign w_fy     = pair_force(r_y[r_i], r_y[r_j]);
   assign w_new_vx = sat_vel(r_vx[r_i], r_acc_x);
   assign w_new_vy = sat_vel(r_vy[r_i], r_acc_y);
   assign w_new_x  = pos_step(r_x[r_i], w_new_vx);
   assign w_new_y  = pos_step(r_y[r_i], w_new_vy);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      w_begin_step = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_begin_step = 1'b1;
               w_state_next = S_ACCUM;
            end else if (load_en) begin
               w_load = 1'b1;
            end
         end
         S_ACCUM: begin
            busy = 1'b1;
            if (r_j == c_last_idx) begin
               w_state_next = S_UPDATE;
            end
         end
         S_UPDATE: begin
            busy = 1'b1;
            w_state_next = (r_i == c_last_idx) ? S_COMMIT : S_ACCUM;
         end
         S_COMMIT: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < N_BODIES; k++) begin
            r_x[k]   <= '0;
            r_y[k]   <= '0;
            r_vx[k]  <= '0;
            r_vy[k]  <= '0;
            r_sx[k]  <= '0;
            r_sy[k]  <= '0;
            r_svx[k] <= '0;
            r_svy[k] <= '0;
         end
         r_i     <= '0;
         r_j     <= '0;
         r_acc_x <= '0;
         r_acc_y <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_begin_step) begin
                  r_i     <= '0;
                  r_j     <= '0;
                  r_acc_x <= '0;
                  r_acc_y <= '0;
               end else if (w_load) begin
                  r_x[load_idx]  <= load_x;
                  r_y[load_idx]  <= load_y;
                  r_vx[load_idx] <= load_vx;
                  r_vy[load_idx] <= load_vy;
               end
            end
            S_ACCUM: begin
               r_acc_x <= r_acc_x + w_fx;
               r_acc_y <= r_acc_y + w_fy;
               r_j     <= r_j + IDX_W'(1);
            end
            S_UPDATE: begin
               r_sx[r_i]  <= w_new_x;
               r_sy[r_i]  <= w_new_y;
               r_svx[r_i] <= w_new_vx;
               r_svy[r_i] <= w_new_vy;
               r_acc_x    <= '0;
               r_acc_y    <= '0;
               r_j        <= '0;
               if (r_i != c_last_idx) begin
                  r_i <= r_i + IDX_W'(1);
               end
            end
            S_COMMIT: begin
               for (int k = 0; k < N_BODIES; k++) begin
                  r_x[k]  <= r_sx[k];
                  r_y[k]  <= r_sy[k];
                  r_vx[k] <= r_svx[k];
                  r_vy[k] <= r_svy[k];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // During the commit cycle the shadow bank already holds the complete new
   // state, so reads are steered to it and the new values appear together
   // with the done pulse.
   always_comb begin
      if (r_state == S_COMMIT) begin
         rd_x  = r_sx[rd_idx];
         rd_y  = r_sy[rd_idx];
         rd_vx = r_svx[rd_idx];
         rd_vy = r_svy[rd_idx];
      end else begin
         rd_x  = r_x[rd_idx];
         rd_y  = r_y[rd_idx];
         rd_vx = r_vx[rd_idx];
         rd_vy = r_vy[rd_idx];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nbody_step_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbody_step_engine
// Description : Self-checking bench for nbody_step_engine. Two instances share
//               all inputs, one wrapping positions and one clamping them, and
//               both are compared against an integer reference model of the
//               N-body step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbody_step_engine;

   localparam int NB = 8;
   localparam int PW = 8;
   localparam int VW = 14;
   localparam int FW = 7;
   localparam int GN = 1;
   localparam int IW = 3;
   localparam int LAT = NB * (NB + 1) + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          load_en;
   logic [IW-1:0] load_idx;
   logic [PW-1:0] load_x, load_y;
   logic [VW-1:0] load_vx, load_vy;
   logic [IW-1:0] rd_idx;
   logic          busy_w, done_w, busy_c, done_c;
   logic [PW-1:0] x_w, y_w, x_c, y_c;
   logic [VW-1:0] vx_w, vy_w, vx_c, vy_c;

   int checks = 0;
   int errors = 0;

   // Reference state: index 0 = wrapping instance, 1 = clamping instance.
   int mx[2][NB], my[2][NB], mvx[2][NB], mvy[2][NB];

   nbody_step_engine #(.N_BODIES(NB), .POS_W(PW), .VEL_W(VW), .FRAC_W(FW),
                       .GAIN(GN), .WRAP_MODE(1)) dut_w (
      .clock(clock), .reset(reset), .start(start), .busy(busy_w), .done(done_w),
      .load_en(load_en), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
      .load_vx(load_vx), .load_vy(load_vy), .rd_idx(rd_idx),
      .rd_x(x_w), .rd_y(y_w), .rd_vx(vx_w), .rd_vy(vy_w));

   nbody_step_engine #(.N_BODIES(NB), .POS_W(PW), .VEL_W(VW), .FRAC_W(FW),
                       .GAIN(GN), .WRAP_MODE(0)) dut_c (
      .clock(clock), .reset(reset), .start(start), .busy(busy_c), .done(done_c),
      .load_en(load_en), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
      .load_vx(load_vx), .load_vy(load_vy), .rd_idx(rd_idx),
      .rd_x(x_c), .rd_y(y_c), .rd_vx(vx_c), .rd_vy(vy_c));

   always #10 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic peek(input int idx);
      rd_idx = IW'(idx);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int floordiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int sat_v(input int v);
      int lim;
      lim = 1 << (VW - 1);
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
   endfunction

   function automatic int fold(input int p, input bit wrap);
      int span;
      span = 1 << PW;
      if (wrap) return ((p % span) + span) % span;
      if (p < 0) return 0;
      if (p > span - 1) return span - 1;
      return p;
   endfunction

   function automatic void model_clear();
      for (int w = 0; w < 2; w++)
         for (int k = 0; k < NB; k++) begin
            mx[w][k] = 0; my[w][k] = 0; mvx[w][k] = 0; mvy[w][k] = 0;
         end
   endfunction

   function automatic void model_step();
      int nx[NB], ny[NB], nvx[NB], nvy[NB];
      int ax, ay;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < NB; i++) begin
            ax = 0;
            ay = 0;
            for (int j = 0; j < NB; j++) begin
               ax += (mx[w][j] - mx[w][i]) * GN;
               ay += (my[w][j] - my[w][i]) * GN;
            end
            nvx[i] = sat_v(mvx[w][i] + ax);
            nvy[i] = sat_v(mvy[w][i] + ay);
            nx[i]  = fold(mx[w][i] + floordiv(nvx[i], 1 << FW), w == 0);
            ny[i]  = fold(my[w][i] + floordiv(nvy[i], 1 << FW), w == 0);
         end
         for (int i = 0; i < NB; i++) begin
            mx[w][i] = nx[i]; my[w][i] = ny[i]; mvx[w][i] = nvx[i]; mvy[w][i] = nvy[i];
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic load_body(input int idx, input int x, input int y, input int vx, input int vy);
      load_en  = 1'b1;
      load_idx = IW'(idx);
      load_x   = PW'(x);
      load_y   = PW'(y);
      load_vx  = VW'(vx);
      load_vy  = VW'(vy);
      cyc();
      load_en  = 1'b0;
      for (int w = 0; w < 2; w++) begin
         mx[w][idx] = x; my[w][idx] = y; mvx[w][idx] = vx; mvy[w][idx] = vy;
      end
   endtask

   task automatic load_random();
      for (int k = 0; k < NB; k++)
         load_body(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
   endtask

   task automatic check_all(input string tag);
      logic [PW-1:0] ep;
      logic [VW-1:0] ev;
      for (int k = 0; k < NB; k++) begin
         rd_idx = IW'(k);
         #1;
         ep = PW'(mx[0][k]);  chk($sformatf("%s wrap x%0d", tag, k), x_w, ep);
         ep = PW'(my[0][k]);  chk($sformatf("%s wrap y%0d", tag, k), y_w, ep);
         ev = VW'(mvx[0][k]); chk($sformatf("%s wrap vx%0d", tag, k), vx_w, ev);
         ev = VW'(mvy[0][k]); chk($sformatf("%s wrap vy%0d", tag, k), vy_w, ev);
         ep = PW'(mx[1][k]);  chk($sformatf("%s clamp x%0d", tag, k), x_c, ep);
         ep = PW'(my[1][k]);  chk($sformatf("%s clamp y%0d", tag, k), y_c, ep);
         ev = VW'(mvx[1][k]); chk($sformatf("%s clamp vx%0d", tag, k), vx_c, ev);
         ev = VW'(mvy[1][k]); chk($sformatf("%s clamp vy%0d", tag, k), vy_c, ev);
      end
   endtask

   // One step. with_load drives a load together with start (must be dropped);
   // busy_load_at drives a load in that busy cycle (must be ignored);
   // reset_at asserts reset in that busy cycle (step abandoned).
   task automatic run_step(input string tag, input bit with_load,
                           input int busy_load_at, input int reset_at);
      int n;
      start = 1'b1;
      if (with_load) begin
         load_en  = 1'b1;
         load_idx = IW'($urandom_range(0, NB - 1));
         load_x   = PW'($urandom);
         load_y   = PW'($urandom);
         load_vx  = VW'($urandom);
         load_vy  = VW'($urandom);
      end
      cyc();
      start   = 1'b0;
      load_en = 1'b0;
      n = 1;
      while (!done_w && n < 200) begin
         if (n == busy_load_at) begin
            load_en  = 1'b1;
            load_idx = IW'($urandom_range(0, NB - 1));
            load_x   = PW'($urandom);
            load_y   = PW'($urandom);
            load_vx  = VW'($urandom);
            load_vy  = VW'($urandom);
         end
         if (n == reset_at) begin
            reset = 1'b1;
            cyc();
            reset = 1'b0;
            model_clear();
            chk({tag, " abort busy"}, busy_w, 1'b0);
            chk({tag, " abort done"}, done_w, 1'b0);
            return;
         end
         cyc();
         load_en = 1'b0;
         n++;
      end
      chk({tag, " latency"}, n, LAT);
      chk({tag, " done clamp inst"}, done_c, 1'b1);
      chk({tag, " busy at commit"}, busy_w, 1'b0);
      model_step();
      cyc();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1; start = 1'b0; load_en = 1'b0; load_idx = '0;
      load_x = '0; load_y = '0; load_vx = '0; load_vy = '0; rd_idx = '0;
      repeat (3) cyc();
      reset = 1'b0;
      model_clear();

      // Reset state
      chk("reset busy", busy_w, 1'b0);
      chk("reset done", done_w, 1'b0);
      chk("reset busy clamp", busy_c, 1'b0);
      check_all("reset");

      // Double buffering / basic physics
      for (int k = 0; k < NB; k++) load_body(k, 50, 50, (k == 3) ? 256 : 0, 0);
      run_step("phys1", 1'b0, 0, 0);
      check_all("phys1");
      peek(3); chk("phys1 b3 x", x_w, 52); chk("phys1 b3 vx", vx_w, 256);
      peek(0); chk("phys1 b0 x", x_w, 50); chk("phys1 b0 vx", vx_w, 0);
      run_step("phys2", 1'b0, 0, 0);
      check_all("phys2");
      peek(3); chk("phys2 b3 x", x_w, 53); chk("phys2 b3 vx", vx_w, 242);
      peek(0); chk("phys2 b0 x", x_w, 50); chk("phys2 b0 vx", vx_w, 2);

      // Cycle-exact latency, start held while busy, start during commit
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         chk($sformatf("lat busy c%0d", k), busy_w, (k <= LAT - 1));
         chk($sformatf("lat done c%0d", k), done_w, (k == LAT));
         if (k == 5) start = 1'b1;
         if (k == 21) start = 1'b0;
         if (k == LAT) begin
            model_step();
            check_all("lat rd at L");
            start = 1'b1;
         end
         if (k < LAT) cyc();
      end
      cyc();
      start = 1'b0;
      chk("lat c74 busy", busy_w, 1'b0);
      chk("lat c74 done", done_w, 1'b0);
      cyc();
      chk("lat c75 busy", busy_w, 1'b0);
      check_all("lat after");

      // Velocity saturation
      for (int k = 0; k < NB; k++) load_body(k, (k == 0) ? 0 : 255, 0, (k == 0) ? 8100 : 0, 0);
      run_step("sat", 1'b0, 0, 0);
      check_all("sat");
      peek(0); chk("sat b0 vx", vx_w, 8191); chk("sat b0 x", x_w, 63); chk("sat b0 x clamp", x_c, 63);

      // Wrap versus clamp
      for (int k = 0; k < NB; k++) load_body(k, 250, 0, (k == 0) ? 1280 : 0, 0);
      run_step("wrap", 1'b0, 0, 0);
      check_all("wrap");
      peek(0); chk("wrap b0 x", x_w, 4); chk("clamp b0 x", x_c, 255); chk("wrap b0 vx", vx_w, 1280);

      // Ignored writes: load during busy, load together with start
      load_random();
      run_step("busyload", 1'b0, 10, 0);
      check_all("busyload");
      run_step("startload", 1'b1, 0, 0);
      check_all("startload");

      // Reset mid-step, then a fresh load and step
      load_random();
      run_step("abort", 1'b0, 0, 30);
      check_all("abort");
      load_random();
      run_step("fresh", 1'b0, 0, 0);
      check_all("fresh");

      // Randomized steps, sometimes chained without reloading
      for (int r = 0; r < 5; r++) begin
         if (r != 2) load_random();
         run_step($sformatf("rnd%0d", r), 1'b0, 0, 0);
         check_all($sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
